// File: rtl/clk_div_meter.sv
// clk_div_meter: measures the period and high time of a slow periodic signal
// in system-clock cycles, and flags a missing rising edge with a timeout pulse.
// sig_in is asynchronous and is resynchronized before any use.
module clk_div_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             timeout_o,
  output logic             stuck_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_CNT     = CNT_W'(1);

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic [CNT_W-1:0]       period_cnt;
  logic [CNT_W-1:0]       high_cnt;

  // Resynchronize sig_in and keep a one-cycle-old copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d    <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;

  // Measurement FSM: first rise arms, each later rise reports the finished period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      period_cnt <= '0;
      high_cnt   <= '0;
      period_o   <= '0;
      high_o     <= '0;
      valid_o    <= 1'b0;
      timeout_o  <= 1'b0;
      stuck_o    <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
      if (!en) begin
        state      <= IDLE;
        period_cnt <= '0;
        high_cnt   <= '0;
        busy_o     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (rise) begin
              state      <= MEAS;
              period_cnt <= ONE_CNT;
              high_cnt   <= ONE_CNT;
              busy_o     <= 1'b1;
            end else begin
              period_cnt <= '0;
              high_cnt   <= '0;
              busy_o     <= 1'b0;
            end
          end
          MEAS: begin
            if (rise) begin
              period_o   <= period_cnt;
              high_o     <= high_cnt;
              valid_o    <= 1'b1;
              period_cnt <= ONE_CNT;
              high_cnt   <= ONE_CNT;
              busy_o     <= 1'b1;
            end else if (period_cnt == TIMEOUT_CNT) begin
              timeout_o  <= 1'b1;
              stuck_o    <= s;
              period_cnt <= '0;
              high_cnt   <= '0;
              state      <= IDLE;
              busy_o     <= 1'b0;
            end else begin
              period_cnt <= period_cnt + ONE_CNT;
              high_cnt   <= high_cnt + CNT_W'(s);
              busy_o     <= 1'b1;
            end
          end
          default: begin
            state      <= IDLE;
            period_cnt <= '0;
            high_cnt   <= '0;
            busy_o     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_div_meter.sv
// tb_clk_div_meter: table-driven pattern checks, hand-written corner sequences
// and random patterns, all compared every cycle against a timestamp-based
// reference model of the meter.
module tb_clk_div_meter;

  localparam int CNT_W = 16;
  localparam int SYNC  = 2;
  localparam int TMO   = 20;
  localparam int HIST  = 12000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             sig_in;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             valid_o;
  logic             timeout_o;
  logic             stuck_o;
  logic             busy_o;

  clk_div_meter #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC),
    .TIMEOUT    (TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sig_in   (sig_in),
    .period_o (period_o),
    .high_o   (high_o),
    .valid_o  (valid_o),
    .timeout_o(timeout_o),
    .stuck_o  (stuck_o),
    .busy_o   (busy_o)
  );

  // 10-unit system clock
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base  = 1;
  logic samp [0:HIST-1];

  logic m_armed   = 1'b0;
  int   m_rise_edge = 0;
  int   m_period  = 0;
  int   m_high    = 0;
  logic m_valid   = 1'b0;
  logic m_timeout = 1'b0;
  logic m_stuck   = 1'b0;

  typedef struct {
    int   hi;
    int   lo;
    int   reps;
    int   exp_period;
    int   exp_high;
    logic exp_tmo;
  } vec_t;

  vec_t vecs [6];

  // Level of sig_in driven before edge k; everything before reset release reads as 0
  function automatic logic lvl(input int k);
    if (k < base || k < 0 || k >= HIST) return 1'b0;
    return samp[k];
  endfunction

  // Reference model: the synchronized level seen by edge n is the input driven
  // two edges earlier; periods are differences of rise timestamps and the high
  // time is the count of high synchronized samples between them.
  task automatic modelEdge(input int n, input logic e);
    logic sv;
    logic rs;
    int   hsum;
    m_valid   = 1'b0;
    m_timeout = 1'b0;
    sv = lvl(n - 2);
    rs = sv & ~lvl(n - 3);
    if (!e) begin
      m_armed = 1'b0;
    end else if (!m_armed) begin
      if (rs) begin
        m_armed     = 1'b1;
        m_rise_edge = n;
      end
    end else if (rs) begin
      hsum = 0;
      for (int k = m_rise_edge; k < n; k++) hsum += lvl(k - 2) ? 1 : 0;
      m_period    = n - m_rise_edge;
      m_high      = hsum;
      m_valid     = 1'b1;
      m_rise_edge = n;
    end else if (n - m_rise_edge == TMO) begin
      m_timeout = 1'b1;
      m_stuck   = sv;
      m_armed   = 1'b0;
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic checkOutput();
    cmp("valid_o",   {31'd0, valid_o},   {31'd0, m_valid});
    cmp("timeout_o", {31'd0, timeout_o}, {31'd0, m_timeout});
    cmp("busy_o",    {31'd0, busy_o},    {31'd0, m_armed});
    cmp("period_o",  {16'd0, period_o},  m_period);
    cmp("high_o",    {16'd0, high_o},    m_high);
    cmp("stuck_o",   {31'd0, stuck_o},   {31'd0, m_stuck});
  endtask

  // Drive one cycle of inputs at negedge, advance the model at posedge, check after
  task automatic applyStimulus(input logic s, input logic e);
    @(negedge clk);
    sig_in = s;
    en     = e;
    @(posedge clk);
    cyc++;
    if (cyc < HIST) samp[cyc] = s;
    modelEdge(cyc, e);
    #1;
    checkOutput();
  endtask

  task automatic modelReset();
    m_armed   = 1'b0;
    m_period  = 0;
    m_high    = 0;
    m_valid   = 1'b0;
    m_timeout = 1'b0;
    m_stuck   = 1'b0;
    base      = cyc + 1;
  endtask

  task automatic checkResetOutputs(input string tag);
    cmp({tag, "_period"},  {16'd0, period_o},  0);
    cmp({tag, "_high"},    {16'd0, high_o},    0);
    cmp({tag, "_valid"},   {31'd0, valid_o},   0);
    cmp({tag, "_timeout"}, {31'd0, timeout_o}, 0);
    cmp({tag, "_stuck"},   {31'd0, stuck_o},   0);
    cmp({tag, "_busy"},    {31'd0, busy_o},    0);
  endtask

  // Hard stop if something goes badly wrong with the flow
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence
  initial begin
    int nval;
    int ntmo;
    int hi;
    int lo;
    int reps;
    int ph;
    logic e;

    vecs[0] = '{hi:4,  lo:3,  reps:6, exp_period:7,  exp_high:4,  exp_tmo:1'b0};
    vecs[1] = '{hi:1,  lo:1,  reps:8, exp_period:2,  exp_high:1,  exp_tmo:1'b0};
    vecs[2] = '{hi:4,  lo:3,  reps:6, exp_period:7,  exp_high:4,  exp_tmo:1'b0};
    vecs[3] = '{hi:10, lo:10, reps:5, exp_period:20, exp_high:10, exp_tmo:1'b0};
    vecs[4] = '{hi:5,  lo:4,  reps:6, exp_period:9,  exp_high:5,  exp_tmo:1'b0};
    vecs[5] = '{hi:10, lo:11, reps:4, exp_period:0,  exp_high:0,  exp_tmo:1'b1};

    rst_n  = 1'b1;
    en     = 1'b0;
    sig_in = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    checkResetOutputs("por");
    @(negedge clk);
    rst_n  = 1'b1;
    sig_in = 1'b0;
    en     = 1'b0;
    modelReset();

    $display("[TB] table-driven pattern vectors");
    for (int v = 0; v < 6; v++) begin
      nval = 0;
      ntmo = 0;
      for (int r = 0; r < vecs[v].reps; r++) begin
        for (int p = 0; p < vecs[v].hi + vecs[v].lo; p++) begin
          applyStimulus(p < vecs[v].hi, 1'b1);
          if (timeout_o) ntmo++;
          if (valid_o) begin
            nval++;
            if (nval > 3) begin
              cmp($sformatf("vec%0d_period", v), {16'd0, period_o}, vecs[v].exp_period);
              cmp($sformatf("vec%0d_high", v),   {16'd0, high_o},   vecs[v].exp_high);
            end
          end
        end
      end
      cmp($sformatf("vec%0d_timeout_seen", v), {31'd0, ntmo > 0}, {31'd0, vecs[v].exp_tmo});
    end

    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b1);

    $display("[TB] held-high timeout");
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, 1'b1);
      cmp($sformatf("hold_timeout_i%0d", i), {31'd0, timeout_o}, {31'd0, i == 22});
      if (i == 22) begin
        cmp("hold_stuck",  {31'd0, stuck_o}, 1);
        cmp("hold_busy",   {31'd0, busy_o},  0);
        cmp("hold_period", {16'd0, period_o}, 9);
        cmp("hold_high",   {16'd0, high_o},   5);
      end
    end

    $display("[TB] two rises nine cycles apart");
    nval = 0;
    for (int i = 0; i < 24; i++) begin
      applyStimulus(i == 4 || i == 13, 1'b1);
      if (valid_o) begin
        nval++;
        cmp("nine_period", {16'd0, period_o}, 9);
        cmp("nine_high",   {16'd0, high_o},   1);
      end
    end
    cmp("nine_valid_count", nval, 1);

    $display("[TB] enable drop and re-enable");
    ph = 0;
    for (int i = 0; i < 28; i++) begin
      applyStimulus((ph % 7) < 4, 1'b1);
      ph++;
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus((ph % 7) < 4, 1'b0);
      ph++;
      cmp("en0_valid",   {31'd0, valid_o},   0);
      cmp("en0_timeout", {31'd0, timeout_o}, 0);
      cmp("en0_busy",    {31'd0, busy_o},    0);
      cmp("en0_period",  {16'd0, period_o},  7);
      cmp("en0_high",    {16'd0, high_o},    4);
    end
    for (int i = 0; i < 21; i++) begin
      applyStimulus((ph % 7) < 4, 1'b1);
      ph++;
      if (i < 7) cmp("reen_early_valid", {31'd0, valid_o}, 0);
    end

    $display("[TB] random patterns");
    for (int seg = 0; seg < 30; seg++) begin
      hi   = $urandom_range(1, 20);
      lo   = $urandom_range(1, 20);
      reps = $urandom_range(1, 3);
      e    = ($urandom_range(0, 7) != 0);
      for (int r = 0; r < reps; r++)
        for (int p = 0; p < hi + lo; p++)
          applyStimulus(p < hi, e);
    end

    $display("[TB] asynchronous reset mid-period");
    for (int i = 0; i < 35; i++) applyStimulus((i % 7) < 4, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checkResetOutputs("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    sig_in = 1'b0;
    en     = 1'b0;
    modelReset();
    for (int i = 0; i < 35; i++) begin
      applyStimulus((i % 7) < 4, 1'b1);
      if (i < 9) cmp("postrst_early_valid", {31'd0, valid_o}, 0);
      if (i == 9) begin
        cmp("postrst_first_valid", {31'd0, valid_o}, 1);
        cmp("postrst_period",      {16'd0, period_o}, 7);
        cmp("postrst_high",        {16'd0, high_o},   4);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
